// File: rtl/writeback.sv
// Writeback stage: GPR/EFLAGS retirement, a store path to the dcache and a REPNE refetch FSM.
// Define WB_STORE_QUEUE_EN to buffer stores in an SQ_DEPTH-entry queue; otherwise stores drive the dcache directly.
module writeback #(
    parameter int          SQ_DEPTH  = 4,
    parameter logic [31:0] FLAGS_RST = 32'h0000_0002
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_V,
    input  logic [31:0] WB_EIP,
    input  logic [31:0] WB_NEIP,
    input  logic        WB_LD_GPR1,
    input  logic        WB_LD_GPR2,
    input  logic        WB_LD_GPR3,
    input  logic        WB_LD_FLAGS,
    input  logic        WB_MEM_WR,
    input  logic        WB_FIRST_REPNE,
    input  logic [1:0]  WB_DATASIZE,
    input  logic [6:0]  WB_FLAGS_AFFECTED,
    input  logic [31:0] WB_ALU32_RESULT,
    input  logic [31:0] WB_FLAGS,
    input  logic [31:0] WB_CMPS_POINTER,
    input  logic [31:0] WB_COUNT,
    input  logic [31:0] WB_ADDRESS,
    input  logic [2:0]  WB_DR1,
    input  logic [2:0]  WB_DR2,
    input  logic [2:0]  WB_DR3,
    output logic        WB_STALL,
    output logic [2:0]  GPR_WE,
    output logic [2:0]  GPR_DR1,
    output logic [2:0]  GPR_DR2,
    output logic [2:0]  GPR_DR3,
    output logic [31:0] GPR_D1,
    output logic [31:0] GPR_D2,
    output logic [31:0] GPR_D3,
    output logic [31:0] FLAGS,
    output logic        DC_WR_V,
    output logic [31:0] DC_WR_ADDR,
    output logic [31:0] DC_WR_DATA,
    output logic [1:0]  DC_WR_SIZE,
    input  logic        DC_WR_ACK,
    output logic        REP_REDIRECT,
    output logic [31:0] REP_EIP
);

    typedef enum logic {
        REP_IDLE   = 1'b0,
        REP_ACTIVE = 1'b1
    } rep_state_e;

    // Mask order is {OF,DF,SF,ZF,AF,PF,CF}; bit 1 of EFLAGS is hardwired to one.
    function automatic logic [31:0] merge_flags(input logic [31:0] cur,
                                                input logic [31:0] upd,
                                                input logic [6:0]  mask);
        logic [31:0] res;
        res = cur;
        if (mask[0]) res[0]  = upd[0];
        if (mask[1]) res[2]  = upd[2];
        if (mask[2]) res[4]  = upd[4];
        if (mask[3]) res[6]  = upd[6];
        if (mask[4]) res[7]  = upd[7];
        if (mask[5]) res[10] = upd[10];
        if (mask[6]) res[11] = upd[11];
        res[1] = 1'b1;
        return res;
    endfunction

    logic        stall;
    logic        retire;
    logic [31:0] flags_p0;
    logic [31:0] flags_nx;
    logic        zf_nx;
    rep_state_e  state_p0;
    rep_state_e  state_nx;
    logic        redirect_nx;
    logic        rep_latch;
    logic        rep_redirect_p0;
    logic [31:0] rep_eip_p0;
    logic        unused_inputs;

    assign unused_inputs = ^{WB_NEIP, WB_FLAGS[31:12], WB_FLAGS[9:8], WB_FLAGS[5],
                             WB_FLAGS[3], WB_FLAGS[1]};

    assign WB_STALL = stall;
    assign retire   = RST & WB_V & ~stall;

    assign GPR_WE  = {3{retire}} & {WB_LD_GPR3, WB_LD_GPR2, WB_LD_GPR1};
    assign GPR_DR1 = WB_DR1;
    assign GPR_DR2 = WB_DR2;
    assign GPR_DR3 = WB_DR3;
    assign GPR_D1  = WB_ALU32_RESULT;
    assign GPR_D2  = WB_CMPS_POINTER;
    assign GPR_D3  = WB_COUNT;

`ifdef WB_STORE_QUEUE_EN
    localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      sq_addr [SQ_DEPTH];
    logic [31:0]      sq_data [SQ_DEPTH];
    logic [1:0]       sq_size [SQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_p0;
    logic [PTR_W-1:0] rd_ptr_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             sq_full;
    logic             sq_empty;
    logic             sq_push;
    logic             sq_pop;

    // Full comes from the registered count, so a same-cycle pop cannot free a slot for the stalled store.
    assign sq_full  = (cnt_p0 == CNT_W'(SQ_DEPTH));
    assign sq_empty = (cnt_p0 == '0);
    assign stall    = RST & WB_V & WB_MEM_WR & sq_full;
    assign sq_push  = retire & WB_MEM_WR;
    assign sq_pop   = ~sq_empty & DC_WR_ACK;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            cnt_p0    <= '0;
        end else begin
            if (sq_push) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
            if (sq_pop)  rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
            case ({sq_push, sq_pop})
                2'b10:   cnt_p0 <= cnt_p0 + CNT_W'(1);
                2'b01:   cnt_p0 <= cnt_p0 - CNT_W'(1);
                default: cnt_p0 <= cnt_p0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (sq_push) begin
            sq_addr[wr_ptr_p0] <= WB_ADDRESS;
            sq_data[wr_ptr_p0] <= WB_ALU32_RESULT;
            sq_size[wr_ptr_p0] <= WB_DATASIZE;
        end
    end

    assign DC_WR_V    = ~sq_empty;
    assign DC_WR_ADDR = sq_addr[rd_ptr_p0];
    assign DC_WR_DATA = sq_data[rd_ptr_p0];
    assign DC_WR_SIZE = sq_size[rd_ptr_p0];
`else
    localparam int UNUSED_SQ_DEPTH = SQ_DEPTH;

    assign DC_WR_V    = RST & WB_V & WB_MEM_WR;
    assign DC_WR_ADDR = WB_ADDRESS;
    assign DC_WR_DATA = WB_ALU32_RESULT;
    assign DC_WR_SIZE = WB_DATASIZE;
    assign stall      = DC_WR_V & ~DC_WR_ACK;
`endif

    assign flags_nx = (retire & WB_LD_FLAGS)
                    ? merge_flags(flags_p0, WB_FLAGS, WB_FLAGS_AFFECTED)
                    : flags_p0;
    assign zf_nx    = flags_nx[6];

    always_ff @(posedge CLK) begin
        if (!RST) flags_p0 <= FLAGS_RST;
        else      flags_p0 <= flags_nx;
    end

    assign FLAGS = flags_p0;

    always_ff @(posedge CLK) begin
        if (!RST) state_p0 <= REP_IDLE;
        else      state_p0 <= state_nx;
    end

    // A retiring REPNE head takes priority over a count write in the same instruction.
    always_comb begin
        state_nx = state_p0;
        case (state_p0)
            REP_IDLE: begin
                if (retire && WB_FIRST_REPNE) state_nx = REP_ACTIVE;
            end
            REP_ACTIVE: begin
                if (retire && WB_FIRST_REPNE) begin
                    state_nx = REP_ACTIVE;
                end else if (retire && WB_LD_GPR3) begin
                    if ((WB_COUNT == 32'd0) || zf_nx) state_nx = REP_IDLE;
                end
            end
            default: state_nx = REP_IDLE;
        endcase
    end

    always_comb begin
        rep_latch   = retire & WB_FIRST_REPNE;
        redirect_nx = 1'b0;
        if ((state_p0 == REP_ACTIVE) && retire && WB_LD_GPR3 && !WB_FIRST_REPNE &&
            (WB_COUNT != 32'd0) && !zf_nx)
            redirect_nx = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rep_redirect_p0 <= 1'b0;
            rep_eip_p0      <= 32'd0;
        end else begin
            rep_redirect_p0 <= redirect_nx;
            if (rep_latch) rep_eip_p0 <= WB_EIP;
        end
    end

    assign REP_REDIRECT = rep_redirect_p0;
    assign REP_EIP      = rep_eip_p0;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback; store traffic is tracked with an expected-store queue.
module tb_writeback;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_V;
    logic [31:0] WB_EIP;
    logic [31:0] WB_NEIP;
    logic        WB_LD_GPR1;
    logic        WB_LD_GPR2;
    logic        WB_LD_GPR3;
    logic        WB_LD_FLAGS;
    logic        WB_MEM_WR;
    logic        WB_FIRST_REPNE;
    logic [1:0]  WB_DATASIZE;
    logic [6:0]  WB_FLAGS_AFFECTED;
    logic [31:0] WB_ALU32_RESULT;
    logic [31:0] WB_FLAGS;
    logic [31:0] WB_CMPS_POINTER;
    logic [31:0] WB_COUNT;
    logic [31:0] WB_ADDRESS;
    logic [2:0]  WB_DR1;
    logic [2:0]  WB_DR2;
    logic [2:0]  WB_DR3;
    logic        WB_STALL;
    logic [2:0]  GPR_WE;
    logic [2:0]  GPR_DR1;
    logic [2:0]  GPR_DR2;
    logic [2:0]  GPR_DR3;
    logic [31:0] GPR_D1;
    logic [31:0] GPR_D2;
    logic [31:0] GPR_D3;
    logic [31:0] FLAGS;
    logic        DC_WR_V;
    logic [31:0] DC_WR_ADDR;
    logic [31:0] DC_WR_DATA;
    logic [1:0]  DC_WR_SIZE;
    logic        DC_WR_ACK;
    logic        REP_REDIRECT;
    logic [31:0] REP_EIP;

    int  n_checks = 0;
    int  n_fail   = 0;
    st_t sb[$];

    writeback #(.SQ_DEPTH(4), .FLAGS_RST(32'h0000_0002)) dut (
        .CLK(CLK), .RST(RST), .WB_V(WB_V), .WB_EIP(WB_EIP), .WB_NEIP(WB_NEIP),
        .WB_LD_GPR1(WB_LD_GPR1), .WB_LD_GPR2(WB_LD_GPR2), .WB_LD_GPR3(WB_LD_GPR3),
        .WB_LD_FLAGS(WB_LD_FLAGS), .WB_MEM_WR(WB_MEM_WR), .WB_FIRST_REPNE(WB_FIRST_REPNE),
        .WB_DATASIZE(WB_DATASIZE), .WB_FLAGS_AFFECTED(WB_FLAGS_AFFECTED),
        .WB_ALU32_RESULT(WB_ALU32_RESULT), .WB_FLAGS(WB_FLAGS),
        .WB_CMPS_POINTER(WB_CMPS_POINTER), .WB_COUNT(WB_COUNT), .WB_ADDRESS(WB_ADDRESS),
        .WB_DR1(WB_DR1), .WB_DR2(WB_DR2), .WB_DR3(WB_DR3), .WB_STALL(WB_STALL),
        .GPR_WE(GPR_WE), .GPR_DR1(GPR_DR1), .GPR_DR2(GPR_DR2), .GPR_DR3(GPR_DR3),
        .GPR_D1(GPR_D1), .GPR_D2(GPR_D2), .GPR_D3(GPR_D3), .FLAGS(FLAGS),
        .DC_WR_V(DC_WR_V), .DC_WR_ADDR(DC_WR_ADDR), .DC_WR_DATA(DC_WR_DATA),
        .DC_WR_SIZE(DC_WR_SIZE), .DC_WR_ACK(DC_WR_ACK),
        .REP_REDIRECT(REP_REDIRECT), .REP_EIP(REP_EIP)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        WB_V = 0; WB_EIP = 0; WB_NEIP = 0;
        WB_LD_GPR1 = 0; WB_LD_GPR2 = 0; WB_LD_GPR3 = 0; WB_LD_FLAGS = 0;
        WB_MEM_WR = 0; WB_FIRST_REPNE = 0; WB_DATASIZE = 0; WB_FLAGS_AFFECTED = 0;
        WB_ALU32_RESULT = 0; WB_FLAGS = 0; WB_CMPS_POINTER = 0; WB_COUNT = 0;
        WB_ADDRESS = 0; WB_DR1 = 0; WB_DR2 = 0; WB_DR3 = 0;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
        WB_V = 1; WB_MEM_WR = 1; WB_ADDRESS = addr; WB_ALU32_RESULT = data; WB_DATASIZE = 2'd2;
    endtask

    task automatic count_write(input logic [31:0] cnt);
        idle_inputs();
        WB_V = 1; WB_LD_GPR3 = 1; WB_COUNT = cnt;
    endtask

    // Acknowledge every head entry and compare it against the oldest expected store.
    task automatic drain(input int budget);
        int cyc;
        st_t e;
        cyc = 0;
        DC_WR_ACK = 1;
        while (sb.size() > 0 && cyc < budget) begin
            settle();
            if (DC_WR_V) begin
                e = sb.pop_front();
                chk("drain_addr", DC_WR_ADDR, e.addr);
                chk("drain_data", DC_WR_DATA, e.data);
                chk("drain_size", {30'd0, DC_WR_SIZE}, {30'd0, e.size});
            end
            tick();
            cyc++;
        end
        DC_WR_ACK = 0;
        chk("drain_left", sb.size(), 32'd0);
        settle();
        chk("drain_empty_v", {31'd0, DC_WR_V}, 32'd0);
    endtask

    initial begin
        st_t e;
        idle_inputs();
        RST = 0; DC_WR_ACK = 0;
        tick(); tick();

        // Inputs asserted while in reset must not stall or write.
        drive_store(32'h100, 32'hA0); WB_LD_GPR1 = 1;
        settle();
        chk("rst_stall", {31'd0, WB_STALL}, 32'd0);
        chk("rst_gpr_we", {29'd0, GPR_WE}, 32'd0);
        idle_inputs();
        RST = 1;
        settle();
        chk("idle_flags", FLAGS, 32'h2);
        chk("idle_dc_v", {31'd0, DC_WR_V}, 32'd0);
        chk("idle_gpr_we", {29'd0, GPR_WE}, 32'd0);
        chk("idle_redirect", {31'd0, REP_REDIRECT}, 32'd0);
        chk("idle_rep_eip", REP_EIP, 32'd0);

        // GPR retirement and pass-through.
        WB_V = 1; WB_LD_GPR1 = 1; WB_LD_GPR3 = 1; WB_DR1 = 3'd5; WB_DR3 = 3'd2;
        WB_ALU32_RESULT = 32'h1234; WB_COUNT = 32'h77; WB_CMPS_POINTER = 32'h55;
        settle();
        chk("gpr_we", {29'd0, GPR_WE}, 32'h5);
        chk("gpr_dr1", {29'd0, GPR_DR1}, 32'd5);
        chk("gpr_d1", GPR_D1, 32'h1234);
        chk("gpr_d2", GPR_D2, 32'h55);
        chk("gpr_d3", GPR_D3, 32'h77);
        WB_V = 0;
        settle();
        chk("gpr_we_novalid", {29'd0, GPR_WE}, 32'd0);
        tick();

        // Flag merging under several masks.
        idle_inputs();
        WB_V = 1; WB_LD_FLAGS = 1; WB_FLAGS_AFFECTED = 7'b0001001; WB_FLAGS = 32'hFFFF_FFFF;
        tick();
        chk("flags_cf_zf", FLAGS, 32'h0000_0043);
        WB_FLAGS_AFFECTED = 7'b1100000;
        tick();
        chk("flags_of_df", FLAGS, 32'h0000_0C43);
        WB_FLAGS_AFFECTED = 7'b0001001; WB_FLAGS = 32'h0;
        tick();
        chk("flags_clear", FLAGS, 32'h0000_0C02);
        WB_V = 0; WB_FLAGS = 32'hFFFF_FFFF; WB_FLAGS_AFFECTED = 7'h7F;
        tick();
        chk("flags_invalid_hold", FLAGS, 32'h0000_0C02);

        // REPNE loop: two redirects, then count zero ends it.
        idle_inputs();
        WB_V = 1; WB_FIRST_REPNE = 1; WB_EIP = 32'h4000;
        tick();
        idle_inputs();
        settle();
        chk("rep_eip_latch", REP_EIP, 32'h4000);
        chk("rep_start_nopulse", {31'd0, REP_REDIRECT}, 32'd0);
        count_write(32'd3);
        tick();
        idle_inputs();
        chk("rep_pulse_cnt3", {31'd0, REP_REDIRECT}, 32'd1);
        tick();
        chk("rep_pulse_cnt3_end", {31'd0, REP_REDIRECT}, 32'd0);
        count_write(32'd2);
        tick();
        idle_inputs();
        chk("rep_pulse_cnt2", {31'd0, REP_REDIRECT}, 32'd1);
        chk("rep_eip_hold", REP_EIP, 32'h4000);
        tick();
        chk("rep_pulse_cnt2_end", {31'd0, REP_REDIRECT}, 32'd0);
        count_write(32'd0);
        tick();
        idle_inputs();
        chk("rep_cnt0_nopulse", {31'd0, REP_REDIRECT}, 32'd0);
        count_write(32'd5);
        tick();
        idle_inputs();
        chk("rep_idle_nopulse", {31'd0, REP_REDIRECT}, 32'd0);

        // Re-latch while active, then ZF=1 termination.
        WB_V = 1; WB_FIRST_REPNE = 1; WB_EIP = 32'h5000;
        tick();
        WB_EIP = 32'h5010;
        tick();
        count_write(32'd7);
        tick();
        idle_inputs();
        chk("rep_relatch_eip", REP_EIP, 32'h5010);
        chk("rep_relatch_pulse", {31'd0, REP_REDIRECT}, 32'd1);
        count_write(32'd4);
        WB_LD_FLAGS = 1; WB_FLAGS_AFFECTED = 7'b0001000; WB_FLAGS = 32'h40;
        tick();
        idle_inputs();
        chk("rep_zf_nopulse", {31'd0, REP_REDIRECT}, 32'd0);
        chk("rep_zf_flags", FLAGS, 32'h0000_0C42);
        count_write(32'd4);
        tick();
        idle_inputs();
        chk("rep_zf_idle", {31'd0, REP_REDIRECT}, 32'd0);

`ifdef WB_STORE_QUEUE_EN
        // Four stores fill the queue; the fifth stalls until a slot frees.
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            settle();
            chk("sq_fill_stall", {31'd0, WB_STALL}, 32'd0);
            e.addr = WB_ADDRESS; e.data = WB_ALU32_RESULT; e.size = WB_DATASIZE;
            sb.push_back(e);
            tick();
        end
        drive_store(32'h110, 32'hA4); WB_LD_GPR1 = 1;
        settle();
        chk("sq_full_stall", {31'd0, WB_STALL}, 32'd1);
        chk("sq_full_gpr_we", {29'd0, GPR_WE}, 32'd0);
        chk("sq_head_v", {31'd0, DC_WR_V}, 32'd1);
        chk("sq_head_addr_hold", DC_WR_ADDR, 32'h100);
        tick();
        chk("sq_head_data_hold", DC_WR_DATA, 32'hA0);
        DC_WR_ACK = 1;
        settle();
        chk("sq_pop_same_cycle_stall", {31'd0, WB_STALL}, 32'd1);
        e = sb.pop_front();
        chk("sq_pop_addr", DC_WR_ADDR, e.addr);
        chk("sq_pop_data", DC_WR_DATA, e.data);
        tick();
        DC_WR_ACK = 0;
        settle();
        chk("sq_fifth_stall", {31'd0, WB_STALL}, 32'd0);
        chk("sq_fifth_gpr_we", {29'd0, GPR_WE}, 32'd1);
        chk("sq_next_head", DC_WR_ADDR, sb[0].addr);
        e.addr = WB_ADDRESS; e.data = WB_ALU32_RESULT; e.size = WB_DATASIZE;
        sb.push_back(e);
        tick();
        idle_inputs();
        drain(20);

        // Reset with three entries pending and no acknowledge.
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
            tick();
        end
        idle_inputs();
        settle();
        chk("sq_pending_v", {31'd0, DC_WR_V}, 32'd1);
        RST = 0;
        tick();
        RST = 1;
        settle();
        chk("sq_rst_v", {31'd0, DC_WR_V}, 32'd0);
        chk("sq_rst_flags", FLAGS, 32'h2);
        chk("sq_rst_rep_eip", REP_EIP, 32'd0);
        sb.delete();
        DC_WR_ACK = 1;
        tick();
        DC_WR_ACK = 0;
        drive_store(32'h200, 32'hB0);
        e.addr = 32'h200; e.data = 32'hB0; e.size = 2'd2;
        sb.push_back(e);
        tick();
        idle_inputs();
        settle();
        chk("sq_fresh_v", {31'd0, DC_WR_V}, 32'd1);
        chk("sq_fresh_head", DC_WR_ADDR, 32'h200);
        drain(10);
`else
        // Direct store path: stalls until acknowledged, blocking retirement.
        drive_store(32'h100, 32'hA0); WB_LD_GPR1 = 1;
        WB_LD_FLAGS = 1; WB_FLAGS_AFFECTED = 7'h7F; WB_FLAGS = 32'h0;
        e.addr = 32'h100; e.data = 32'hA0; e.size = 2'd2;
        sb.push_back(e);
        settle();
        chk("dir_v", {31'd0, DC_WR_V}, 32'd1);
        chk("dir_addr", DC_WR_ADDR, sb[0].addr);
        chk("dir_data", DC_WR_DATA, sb[0].data);
        chk("dir_size", {30'd0, DC_WR_SIZE}, {30'd0, sb[0].size});
        chk("dir_stall", {31'd0, WB_STALL}, 32'd1);
        chk("dir_stall_gpr_we", {29'd0, GPR_WE}, 32'd0);
        tick();
        chk("dir_stall_flags", FLAGS, 32'h0000_0C42);
        DC_WR_ACK = 1;
        settle();
        chk("dir_ack_stall", {31'd0, WB_STALL}, 32'd0);
        chk("dir_ack_gpr_we", {29'd0, GPR_WE}, 32'd1);
        void'(sb.pop_front());
        tick();
        chk("dir_retire_flags", FLAGS, 32'h2);
        chk("dir_sb_empty", sb.size(), 32'd0);
        DC_WR_ACK = 0;
        drive_store(32'h104, 32'hA1);
        RST = 0;
        settle();
        chk("dir_rst_v", {31'd0, DC_WR_V}, 32'd0);
        chk("dir_rst_stall", {31'd0, WB_STALL}, 32'd0);
        tick();
        idle_inputs();
        RST = 1;
        settle();
        chk("dir_rst_flags", FLAGS, 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
